// File: rtl/store_pack_pkg.sv
// Shared types and encodings for the store packing path.
// ALU op codes mirror the core's store subset; masks are byte-lane strobes.
package store_pack_pkg;

  localparam int ALU_OP_W = 8;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD = 8'h20;
  localparam alu_op_t ALU_OP_SB  = 8'h28;
  localparam alu_op_t ALU_OP_SH  = 8'h29;
  localparam alu_op_t ALU_OP_SW  = 8'h2B;

  localparam logic [3:0]  MASK_BYTE = 4'b0001;
  localparam logic [3:0]  MASK_HALF = 4'b0011;
  localparam logic [3:0]  MASK_WORD = 4'b1111;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } st_entry_t;

endpackage

// File: rtl/store_pack_if.sv
// Store request channel from Execute plus write channel toward Data_Mem.
// master = environment side (Execute and Data_Mem), slave = store_pack.
interface store_pack_if;
  import store_pack_pkg::*;

  logic        st_valid_i;
  logic        st_ready_o;
  alu_op_t     alu_op_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;

  logic        wmem_valid_o;
  logic        wmem_ready_i;
  logic [31:0] wmem_addr_o;
  logic [31:0] wmem_data_o;
  logic [3:0]  wmem_mask_o;

  modport master (
    output st_valid_i, alu_op_i, st_addr_i, st_data_i, wmem_ready_i,
    input  st_ready_o, wmem_valid_o, wmem_addr_o, wmem_data_o, wmem_mask_o
  );

  modport slave (
    input  st_valid_i, alu_op_i, st_addr_i, st_data_i, wmem_ready_i,
    output st_ready_o, wmem_valid_o, wmem_addr_o, wmem_data_o, wmem_mask_o
  );

endinterface

// File: rtl/store_pack_lane_pack.sv
// Combinational SB/SH/SW decode: byte strobe, lane-shifted data, misalign flag.
// Non-store ops produce is_store = 0 and all-zero outputs.
module store_lane_pack
  import store_pack_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] packed_data,
  output logic        is_store,
  output logic        misalign
);

  logic [4:0] shamt;
  assign shamt = {offset, 3'b000};

  always_comb begin
    mask        = 4'b0000;
    packed_data = ZERO_WORD;
    is_store    = 1'b0;
    misalign    = 1'b0;
    case (alu_op)
      ALU_OP_SB: begin
        is_store    = 1'b1;
        mask        = MASK_BYTE << offset;
        packed_data = {24'h0, data[7:0]} << shamt;
      end
      ALU_OP_SH: begin
        is_store    = 1'b1;
        misalign    = offset[0];
        mask        = MASK_HALF << offset;
        packed_data = {16'h0, data[15:0]} << shamt;
      end
      ALU_OP_SW: begin
        is_store    = 1'b1;
        misalign    = |offset;
        mask        = MASK_WORD;
        packed_data = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_pack.sv
// Store buffer: packs stores into word writes, queues them, drains in order to Data_Mem.
// One-cycle latency to wmem_*; st_ready_o is simply not-full, so a same-cycle pop never frees a slot early.
module store_pack
  import store_pack_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  store_pack_if.slave sif,
  input  logic [31:0] ld_addr_i,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
  output logic        hazard_o,
  output logic        pending_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  st_entry_t        mem_q [DEPTH];
  st_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      misalign_addr_q, misalign_addr_d;

  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic        lane_is_store;
  logic        lane_misalign;

  store_lane_pack u_lane (
    .alu_op      (sif.alu_op_i),
    .offset      (sif.st_addr_i[1:0]),
    .data        (sif.st_data_i),
    .mask        (lane_mask),
    .packed_data (lane_data),
    .is_store    (lane_is_store),
    .misalign    (lane_misalign)
  );

  logic empty, full, st_rdy, hs, push, drop, pop;
  st_entry_t head;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign st_rdy = !full;
  assign hs     = sif.st_valid_i && st_rdy && lane_is_store;
  assign push   = hs && !lane_misalign;
  assign drop   = hs && lane_misalign;
  assign pop    = !empty && sif.wmem_ready_i;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    misalign_d      = drop;
    misalign_addr_d = misalign_addr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{waddr: sif.st_addr_i[31:2], data: lane_data, mask: lane_mask};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      misalign_addr_d = sif.st_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= ZERO_WORD;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Slot i is live when its distance from the read pointer is below the occupancy.
  logic [PTR_W-1:0] rel;
  always_comb begin
    hazard_o = 1'b0;
    rel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) && (mem_q[i].waddr == ld_addr_i[31:2])) begin
        hazard_o = 1'b1;
      end
    end
  end

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr_i[1:0];

  assign sif.st_ready_o   = st_rdy;
  assign sif.wmem_valid_o = !empty;
  assign sif.wmem_addr_o  = {head.waddr, 2'b00};
  assign sif.wmem_data_o  = head.data;
  assign sif.wmem_mask_o  = head.mask;
  assign misalign_o       = misalign_q;
  assign misalign_addr_o  = misalign_addr_q;
  assign pending_o        = !empty;

endmodule

// File: tb/tb_store_pack.sv
// Directed bench for store_pack: lane packing, misalign, backpressure, hazard, async reset.
module tb_store_pack;
  import store_pack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ld_addr;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        hazard;
  logic        pending;

  int n_checks   = 0;
  int n_failures = 0;

  store_pack_if sif ();

  store_pack #(.DEPTH(2), .PTR_W(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .sif             (sif),
    .ld_addr_i       (ld_addr),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr),
    .hazard_o        (hazard),
    .pending_o       (pending)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_t op, input logic [31:0] addr, input logic [31:0] data);
    sif.st_valid_i = 1'b1;
    sif.alu_op_i   = op;
    sif.st_addr_i  = addr;
    sif.st_data_i  = data;
  endtask

  // One-cycle request, then idle; outputs checked one cycle after the accept edge.
  task automatic store(input alu_op_t op, input logic [31:0] addr, input logic [31:0] data);
    drive(op, addr, data);
    tick();
    sif.st_valid_i = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    check({tag, "_valid"}, {31'h0, sif.wmem_valid_o}, 32'h1);
    check({tag, "_addr"},  sif.wmem_addr_o, a);
    check({tag, "_data"},  sif.wmem_data_o, d);
    check({tag, "_mask"},  {28'h0, sif.wmem_mask_o}, {28'h0, m});
  endtask

  initial begin
    rst              = 1'b1;
    sif.st_valid_i   = 1'b0;
    sif.alu_op_i     = ALU_OP_ADD;
    sif.st_addr_i    = 32'h0;
    sif.st_data_i    = 32'h0;
    sif.wmem_ready_i = 1'b0;
    ld_addr          = 32'hFFFF_FFF0;

    tick();
    check("rst_ready",    {31'h0, sif.st_ready_o}, 32'h1);
    check("rst_wvalid",   {31'h0, sif.wmem_valid_o}, 32'h0);
    check("rst_pending",  {31'h0, pending}, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_maddr",    misalign_addr, 32'h0);
    check("rst_wdata",    sif.wmem_data_o, 32'h0);
    rst = 1'b0;
    tick();

    // SB into lane 3
    store(ALU_OP_SB, 32'h8000_0003, 32'h1234_56AB);
    expect_head("sb", 32'h8000_0000, 32'hAB00_0000, 4'b1000);
    check("sb_pending", {31'h0, pending}, 32'h1);
    check("sb_ready",   {31'h0, sif.st_ready_o}, 32'h1);
    sif.wmem_ready_i = 1'b1;
    tick();
    check("sb_drained", {31'h0, sif.wmem_valid_o}, 32'h0);
    sif.wmem_ready_i = 1'b0;

    store(ALU_OP_SH, 32'h0000_1002, 32'hFFFF_BEEF);
    expect_head("sh", 32'h0000_1000, 32'hBEEF_0000, 4'b1100);
    sif.wmem_ready_i = 1'b1;
    tick();
    sif.wmem_ready_i = 1'b0;

    store(ALU_OP_SW, 32'h0000_1004, 32'hCAFE_F00D);
    expect_head("sw", 32'h0000_1004, 32'hCAFE_F00D, 4'b1111);
    sif.wmem_ready_i = 1'b1;
    tick();
    check("sw_drained", {31'h0, pending}, 32'h0);
    sif.wmem_ready_i = 1'b0;

    // Misaligned SW: dropped, one-cycle pulse, address held
    store(ALU_OP_SW, 32'h0000_1006, 32'h1111_2222);
    check("msw_pulse",  {31'h0, misalign}, 32'h1);
    check("msw_addr",   misalign_addr, 32'h0000_1006);
    check("msw_nowr",   {31'h0, sif.wmem_valid_o}, 32'h0);
    tick();
    check("msw_pulse_end", {31'h0, misalign}, 32'h0);
    check("msw_addr_held", misalign_addr, 32'h0000_1006);

    store(ALU_OP_SH, 32'h0000_1001, 32'h3333_4444);
    check("msh_pulse", {31'h0, misalign}, 32'h1);
    check("msh_addr",  misalign_addr, 32'h0000_1001);
    check("msh_nowr",  {31'h0, pending}, 32'h0);
    tick();
    check("msh_pulse_end", {31'h0, misalign}, 32'h0);

    // Non-store op is ignored
    store(ALU_OP_ADD, 32'h0000_2000, 32'h5555_5555);
    check("add_ignored", {31'h0, sif.wmem_valid_o}, 32'h0);
    check("add_nomis",   {31'h0, misalign}, 32'h0);

    // Backpressure: fill, stall a third request, then drain in order
    store(ALU_OP_SW, 32'h0000_0200, 32'h1111_1111);
    store(ALU_OP_SB, 32'h0000_0205, 32'h0000_0022);
    check("full_ready", {31'h0, sif.st_ready_o}, 32'h0);
    expect_head("full_head0", 32'h0000_0200, 32'h1111_1111, 4'b1111);
    drive(ALU_OP_SW, 32'h0000_0300, 32'h3333_3333);
    tick();
    check("stall_ready", {31'h0, sif.st_ready_o}, 32'h0);
    expect_head("stall_head", 32'h0000_0200, 32'h1111_1111, 4'b1111);
    sif.wmem_ready_i = 1'b1;
    tick();
    expect_head("pop1_head", 32'h0000_0204, 32'h0000_2200, 4'b0010);
    check("pop1_ready", {31'h0, sif.st_ready_o}, 32'h1);
    tick();
    expect_head("pushpop_head", 32'h0000_0300, 32'h3333_3333, 4'b1111);
    check("pushpop_ready", {31'h0, sif.st_ready_o}, 32'h1);
    check("pushpop_pend",  {31'h0, pending}, 32'h1);
    sif.st_valid_i = 1'b0;
    tick();
    check("bp_empty", {31'h0, sif.wmem_valid_o}, 32'h0);
    sif.wmem_ready_i = 1'b0;

    // Hazard against a buffered SB
    store(ALU_OP_SB, 32'h0000_0100, 32'h0000_0055);
    ld_addr = 32'h0000_0103;
    #1;
    check("hz_match", {31'h0, hazard}, 32'h1);
    ld_addr = 32'h0000_0104;
    #1;
    check("hz_other", {31'h0, hazard}, 32'h0);
    ld_addr = 32'h0000_0103;
    sif.wmem_ready_i = 1'b1;
    tick();
    check("hz_drained", {31'h0, hazard}, 32'h0);
    sif.wmem_ready_i = 1'b0;

    // Async reset mid-drain with two entries held
    store(ALU_OP_SW, 32'h0000_0400, 32'hAAAA_AAAA);
    store(ALU_OP_SW, 32'h0000_0404, 32'hBBBB_BBBB);
    check("prerst_pend", {31'h0, pending}, 32'h1);
    sif.wmem_ready_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_wvalid",  {31'h0, sif.wmem_valid_o}, 32'h0);
    check("arst_pending", {31'h0, pending}, 32'h0);
    check("arst_ready",   {31'h0, sif.st_ready_o}, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_wvalid", {31'h0, sif.wmem_valid_o}, 32'h0);
    check("postrst_hazard", {31'h0, hazard}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/store_pack.md
Name: store_pack

Overview:
- Store-path counterpart of the load-data expander.
- Takes SB/SH/SW requests from Execute and packs rs2 data into the correct byte lanes of a word-aligned write.
- Generates a 4-bit byte-write strobe and buffers requests in a small FIFO.
- Drains the FIFO to Data_Mem over a valid/ready handshake; also flags misaligned stores and load-after-store address hazards.

Parameters:
- DEPTH, 2, store buffer entries; power of two, minimum 2.
- PTR_W, 1, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset (`RST_ENABLE).
- st_valid_i  input  1  Execute presents a request.
- st_ready_o  output  1  buffer can accept; equals not-full.
- alu_op_i  input  `ALU_OP_BUS  operation; only `ALU_OP_SB/SH/SW act.
- st_addr_i  input  32  full byte address.
- st_data_i  input  32  rs2 value.
- wmem_valid_o  output  1  head entry valid toward Data_Mem.
- wmem_ready_i  input  1  Data_Mem accepts head.
- wmem_addr_o  output  32  head word address, bits [1:0] = 0.
- wmem_data_o  output  32  lane-shifted data.
- wmem_mask_o  output  4  byte strobe, bit n = byte lane n.
- misalign_o  output  1  one-cycle pulse: store dropped as misaligned.
- misalign_addr_o  output  32  address of last misaligned store, held.
- ld_addr_i  input  32  address of a load in flight.
- hazard_o  output  1  ld word address matches a buffered store.
- pending_o  output  1  buffer non-empty.

Behaviour:
- Reset, asynchronous:
  - FIFO emptied, pointers and count = 0.
  - All outputs 0 except st_ready_o = 1.
  - Stores in flight are dropped; no partial write issues after reset.
- Accept: st_valid_i && st_ready_o && op in {SB,SH,SW} && aligned. Entry is written on that edge.
- Any other alu_op with st_valid_i: ignored, no state change.
- Alignment:
  - SH is misaligned when addr[0] = 1.
  - SW is misaligned when addr[1:0] != 0.
  - SB is always aligned.
- Misaligned store:
  - Not enqueued.
  - misalign_o = 1 in the next cycle only.
  - misalign_addr_o latches st_addr_i.
  - Consumes the handshake; st_ready_o must be 1 for it to count.
- Packing, off = addr[1:0]:
  - SB: mask = 4'b0001 << off; data = st_data_i[7:0] << 8*off.
  - SH: mask = 4'b0011 << off; data = st_data_i[15:0] << 8*off.
  - SW: mask = 4'b1111; data = st_data_i.
  - Unused lanes are 0.
  - wmem_addr_o = {addr[31:2], 2'b00}.
- Latency: request accepted at edge N with buffer empty appears on wmem_* during cycle N+1. There is no combinational pass-through.
- Drain:
  - wmem_valid_o = !empty.
  - Head is popped on wmem_valid_o && wmem_ready_i.
  - wmem_addr/data/mask stay stable while valid && !ready.
- Full: st_ready_o = 0 when count == DEPTH, even if a pop occurs that cycle. No enqueue while full.
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged, order preserved.
- Pointers wrap modulo DEPTH. Count runs 0..DEPTH, width PTR_W+1.
- hazard_o is combinational: 1 if ld_addr_i[31:2] equals the word address of any valid entry. The entry being pushed this cycle is not included.
- pending_o = !empty, registered from count.
- Entries drain in program order; no store merging or reordering.

Decomposition:
- Add to defines.v:
  - `STORE_MASK_BUS [3:0]
  - `MASK_BYTE 4'b0001, `MASK_HALF 4'b0011, `MASK_WORD 4'b1111
  - reuse existing `ALU_OP_SB/SH/SW and `ZERO_WORD
- One combinational sub-module, store_lane_pack:
  - inputs alu_op, offset, data
  - outputs mask, packed data, misalign flag
- FIFO and handshake logic stay in store_pack.

Test Plan:
- **Reset:** assert rst mid-drain with 2 entries held → wmem_valid_o = 0, pending_o = 0, st_ready_o = 1 immediately, before any clock edge.
- **SB lanes:** SB addr 0x8000_0003, data 0x1234_56AB → next cycle wmem_addr 0x8000_0000, data 0xAB00_0000, mask 4'b1000.
- **SH and SW:** SH addr 0x...02, data 0xFFFF_BEEF → data 0xBEEF_0000, mask 4'b1100. SW addr 0x...04 → mask 4'b1111, data unchanged.
- **Misaligned:** SW addr 0x...06 → no wmem_valid_o, misalign_o pulses one cycle, misalign_addr_o = 0x...06. Same for SH addr 0x...01.
- **Backpressure and full:**
  - wmem_ready_i = 0; push 2 stores → st_ready_o = 0, third request stalls, wmem outputs hold entry 0.
  - Raise ready → entries pop in order, st_ready_o returns 1 the cycle after the first pop.
  - Push and pop together at count 1 → count stays 1.
- **Hazard:** buffer holds SB at 0x100 → ld_addr 0x103 gives hazard_o = 1, ld_addr 0x104 gives 0; after the entry drains, hazard_o = 0.
